// File: rtl/udp_rx_payload_assembler.sv
// Packs a UDP payload byte burst MSB-first into one wide word and hands it to the user through
// valid/ready; bursts arriving while a word is pending are dropped. Optional: UDP_RX_LEN_CHECK_EN.
module udp_rx_payload_assembler #(
   parameter int DATA_W = 960,
   parameter int LEN_W  = 16
) (
   input  logic              rgmii_clk,
   input  logic              rstn,
   input  logic              udp_rec_data_valid,
   input  logic [7:0]        udp_rec_rdata,
   input  logic [LEN_W-1:0]  udp_rec_data_length,
   output logic              rx_payload_valid,
   input  logic              rx_payload_ready,
   output logic [DATA_W-1:0] rx_payload,
   output logic [LEN_W-1:0]  rx_payload_length,
   output logic              rx_payload_trunc,
   output logic              rx_len_err,
   output logic [LEN_W-1:0]  rx_drop_cnt
);
   localparam int               MAXB   = DATA_W / 8;
   localparam logic [LEN_W-1:0] MAXB_L = LEN_W'(MAXB);
   localparam logic [LEN_W-1:0] ONES   = {LEN_W{1'b1}};
   localparam logic [LEN_W-1:0] ONE    = {{(LEN_W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      HOLD    = 2'd2,
      DROP    = 2'd3
   } state_t;

   function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] val);
      logic [LEN_W-1:0] res;
      if (val == ONES) begin
         res = val;
      end else begin
         res = val + ONE;
      end
      return res;
   endfunction

   state_t             state_r, state_s;
   logic [LEN_W-1:0]   cnt_r, cnt_s;
   logic [DATA_W-1:0]  buf_r, buf_s;
   logic               acc_trunc_r, acc_trunc_s;
   logic [LEN_W-1:0]   len_r, len_s;
   logic               trunc_r, trunc_s;
   logic               pv_r, pv_s;
   logic [LEN_W-1:0]   drop_r, drop_s;
   logic               start_s;
   logic               close_s;
   logic [DATA_W-1:0]  first_word_s;
   logic [DATA_W-1:0]  slot_word_s;

   // Byte placed at the MSB slot, then shifted down to slot cnt (bit offset (MAXB-1-cnt)*8).
   assign first_word_s = {udp_rec_rdata, {(DATA_W-8){1'b0}}};
   assign slot_word_s  = first_word_s >> {cnt_r, 3'b000};

   // State register; reset lands in DROP so a burst already in flight is rejected.
   always_ff @(posedge rgmii_clk or negedge rstn) begin
      if (!rstn) begin
         state_r <= DROP;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state and datapath next values.
   always_comb begin
      state_s     = state_r;
      cnt_s       = cnt_r;
      buf_s       = buf_r;
      acc_trunc_s = acc_trunc_r;
      len_s       = len_r;
      trunc_s     = trunc_r;
      pv_s        = pv_r;
      drop_s      = drop_r;
      start_s     = 1'b0;
      close_s     = 1'b0;
      case (state_r)
         IDLE: begin
            if (udp_rec_data_valid) begin
               start_s     = 1'b1;
               state_s     = COLLECT;
               buf_s       = first_word_s;
               cnt_s       = ONE;
               acc_trunc_s = 1'b0;
            end else begin
               state_s = IDLE;
            end
         end
         COLLECT: begin
            if (udp_rec_data_valid) begin
               if (cnt_r < MAXB_L) begin
                  buf_s = buf_r | slot_word_s;
                  cnt_s = cnt_r + ONE;
               end else begin
                  acc_trunc_s = 1'b1;
               end
            end else begin
               close_s = 1'b1;
               state_s = HOLD;
               pv_s    = 1'b1;
               len_s   = cnt_r;
               trunc_s = acc_trunc_r;
            end
         end
         HOLD: begin
            if (rx_payload_ready) begin
               // The accepting cycle may also carry the first byte of the next datagram.
               if (udp_rec_data_valid) begin
                  start_s     = 1'b1;
                  state_s     = COLLECT;
                  buf_s       = first_word_s;
                  cnt_s       = ONE;
                  acc_trunc_s = 1'b0;
                  pv_s        = 1'b0;
               end else begin
                  pv_s    = 1'b0;
                  state_s = IDLE;
               end
            end else if (udp_rec_data_valid) begin
               drop_s  = sat_inc(drop_r);
               state_s = DROP;
            end else begin
               state_s = HOLD;
            end
         end
         DROP: begin
            if (rx_payload_ready) begin
               pv_s = 1'b0;
            end else begin
               pv_s = pv_r;
            end
            if (udp_rec_data_valid) begin
               state_s = DROP;
            end else if (pv_s) begin
               state_s = HOLD;
            end else begin
               state_s = IDLE;
            end
         end
         default: begin
            state_s = DROP;
         end
      endcase
   end

   // Datapath and output registers.
   always_ff @(posedge rgmii_clk or negedge rstn) begin
      if (!rstn) begin
         cnt_r       <= {LEN_W{1'b0}};
         buf_r       <= {DATA_W{1'b0}};
         acc_trunc_r <= 1'b0;
         len_r       <= {LEN_W{1'b0}};
         trunc_r     <= 1'b0;
         pv_r        <= 1'b0;
         drop_r      <= {LEN_W{1'b0}};
      end else begin
         cnt_r       <= cnt_s;
         buf_r       <= buf_s;
         acc_trunc_r <= acc_trunc_s;
         len_r       <= len_s;
         trunc_r     <= trunc_s;
         pv_r        <= pv_s;
         drop_r      <= drop_s;
      end
   end

   assign rx_payload_valid  = pv_r;
   assign rx_payload        = buf_r;
   assign rx_payload_length = len_r;
   assign rx_payload_trunc  = trunc_r;
   assign rx_drop_cnt       = drop_r;

`ifdef UDP_RX_LEN_CHECK_EN
   logic [LEN_W-1:0] cnt_raw_r, cnt_raw_s;
   logic [LEN_W-1:0] exp_len_r, exp_len_s;
   logic             len_err_r, len_err_s;

   // Raw burst count and advertised length are latched at start, compared at close.
   always_comb begin
      cnt_raw_s = cnt_raw_r;
      exp_len_s = exp_len_r;
      len_err_s = len_err_r;
      if (start_s) begin
         cnt_raw_s = ONE;
         exp_len_s = udp_rec_data_length;
      end else if ((state_r == COLLECT) && udp_rec_data_valid) begin
         cnt_raw_s = sat_inc(cnt_raw_r);
      end else begin
         cnt_raw_s = cnt_raw_r;
      end
      if (close_s) begin
         len_err_s = (cnt_raw_r != exp_len_r);
      end else begin
         len_err_s = len_err_r;
      end
   end

   // Length-check registers.
   always_ff @(posedge rgmii_clk or negedge rstn) begin
      if (!rstn) begin
         cnt_raw_r <= {LEN_W{1'b0}};
         exp_len_r <= {LEN_W{1'b0}};
         len_err_r <= 1'b0;
      end else begin
         cnt_raw_r <= cnt_raw_s;
         exp_len_r <= exp_len_s;
         len_err_r <= len_err_s;
      end
   end

   assign rx_len_err = len_err_r;
`else
   logic unused_len_s;
   assign unused_len_s = ^{udp_rec_data_length, start_s, close_s};
   assign rx_len_err   = 1'b0;
`endif

endmodule
